// File: rtl/crypto_round_engine.sv
// Iterated rotate/XOR block cipher with encrypt and decrypt modes.
// One block in flight; valid/ready on both sides, result held under backpressure.
module crypto_round_engine #(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned ROUND_COUNT = 8,
  parameter int unsigned ROT_AMT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0] in_key,
  input  logic [63:0]           aux_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  localparam int unsigned CNT_W   = $clog2(ROUND_COUNT + 1);
  localparam int unsigned DEC_ROT = ((ROUND_COUNT - 1) * ROT_AMT) % DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUND_COUNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  state_t                state, state_next;
  logic                  mode;
  logic [DATA_WIDTH-1:0] st, rk, st_next, rk_next;
  logic [CNT_W-1:0]      cnt;
  logic                  accept, last_round;

  function automatic logic [DATA_WIDTH-1:0] rotl(input logic [DATA_WIDTH-1:0] x,
                                                 input int unsigned n);
    int unsigned s;
    s = n % DATA_WIDTH;
    if (s == 0) return x;
    return (x << s) | (x >> (DATA_WIDTH - s));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x,
                                                 input int unsigned n);
    int unsigned s;
    s = n % DATA_WIDTH;
    if (s == 0) return x;
    return (x >> s) | (x << (DATA_WIDTH - s));
  endfunction

  assign in_ready   = (state == S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign accept     = in_valid && in_ready;
  assign last_round = (state == S_ROUND) && (cnt == LAST_RND);

  always_comb begin
    st_next = st;
    rk_next = rk;
    if (mode) begin
      st_next = rotr(st, 1) ^ rk;
      rk_next = rotr(rk, ROT_AMT);
    end else begin
      st_next = rotl(st ^ rk, 1);
      rk_next = rotl(rk, ROT_AMT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (accept)     state_next = S_ROUND;
      S_ROUND: if (last_round) state_next = S_DONE;
      S_DONE:  if (out_ready)  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Decrypt walks the key schedule backwards, so it starts from the last round key.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode     <= 1'b0;
      st       <= '0;
      rk       <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else if (accept) begin
      mode <= in_mode;
      st   <= in_data;
      rk   <= in_mode ? rotl(in_key, DEC_ROT) : in_key;
      cnt  <= '0;
    end else if (state == S_ROUND) begin
      st  <= st_next;
      rk  <= rk_next;
      cnt <= cnt + CNT_W'(1);
      if (last_round) out_data <= st_next ^ DATA_WIDTH'(aux_mask);
    end
  end

endmodule

// File: tb/tb_crypto_round_engine.sv
// Directed bench for crypto_round_engine: three parameterisations checked against
// a loop-level cipher model, plus hand-computed literal expectations.
module tb_crypto_round_engine;

  localparam int unsigned W  = 128;
  localparam int unsigned NI = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NI-1:0] in_valid_v = '0;
  logic          in_mode = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [W-1:0]  in_key = '0;
  logic [63:0]   aux_mask = '0;
  logic          out_ready = 1'b1;
  logic [NI-1:0] in_ready_v, out_valid_v, busy_v;
  logic [W-1:0]  out_data_v [NI];

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [NI-1:0] pending = '0;
  logic [W-1:0]  exp_data [NI];
  int unsigned   acc_cyc [NI];
  int unsigned   cyc = 0;

  always #5 clk = ~clk;

  crypto_round_engine #(.DATA_WIDTH(128), .ROUND_COUNT(8), .ROT_AMT(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_mode(in_mode), .in_data(in_data), .in_key(in_key), .aux_mask(aux_mask),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_data(out_data_v[0]),
    .busy(busy_v[0]));

  crypto_round_engine #(.DATA_WIDTH(128), .ROUND_COUNT(1), .ROT_AMT(7)) u_r1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_mode(in_mode), .in_data(in_data), .in_key(in_key), .aux_mask(aux_mask),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_data(out_data_v[1]),
    .busy(busy_v[1]));

  crypto_round_engine #(.DATA_WIDTH(128), .ROUND_COUNT(3), .ROT_AMT(7)) u_r3 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_mode(in_mode), .in_data(in_data), .in_key(in_key), .aux_mask(aux_mask),
    .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_data(out_data_v[2]),
    .busy(busy_v[2]));

  function automatic int unsigned rc(input int unsigned i);
    return (i == 0) ? 8 : ((i == 1) ? 1 : 3);
  endfunction

  function automatic int unsigned ra(input int unsigned i);
    return (i == 0) ? 1 : 7;
  endfunction

  function automatic logic [W-1:0] brotl(input logic [W-1:0] x, input int unsigned n);
    int unsigned s;
    s = n % W;
    if (s == 0) return x;
    return (x << s) | (x >> (W - s));
  endfunction

  function automatic logic [W-1:0] brotr(input logic [W-1:0] x, input int unsigned n);
    return brotl(x, W - (n % W));
  endfunction

  // Round i uses key rotl(K, i*A); decrypt applies the inverse rounds in reverse order.
  function automatic logic [W-1:0] model(input logic mode, input logic [W-1:0] d,
                                         input logic [W-1:0] k, input logic [63:0] m,
                                         input int unsigned r, input int unsigned a);
    logic [W-1:0] s;
    s = d;
    for (int unsigned j = 0; j < r; j++) begin
      if (!mode) s = brotl(s ^ brotl(k, j * a), 1);
      else       s = brotr(s, 1) ^ brotl(k, (r - 1 - j) * a);
    end
    return s ^ {64'h0, m};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < NI; i++) begin
        if (in_valid_v[i] && in_ready_v[i]) begin
          pending[i]  <= 1'b1;
          exp_data[i] <= model(in_mode, in_data, in_key, aux_mask, rc(i), ra(i));
          acc_cyc[i]  <= cyc + 1;
        end else if (out_valid_v[i] && out_ready) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic exp_v;
      exp_v = pending[i] && ((cyc - acc_cyc[i]) >= rc(i));
      chk($sformatf("in_ready[%0d]", i), W'(in_ready_v[i]), W'(!pending[i]));
      chk($sformatf("busy[%0d]", i), W'(busy_v[i]), W'(pending[i]));
      chk($sformatf("out_valid[%0d]", i), W'(out_valid_v[i]), W'(exp_v));
      if (exp_v) chk($sformatf("out_data[%0d]", i), out_data_v[i], exp_data[i]);
      if (!rst) chk($sformatf("rst_out_data[%0d]", i), out_data_v[i], '0);
    end
  end

  task automatic start(input int unsigned i, input logic mode, input logic [W-1:0] d,
                       input logic [W-1:0] k, input logic [63:0] m);
    int unsigned n;
    @(posedge clk); #1;
    in_mode = mode; in_data = d; in_key = k; aux_mask = m;
    in_valid_v[i] = 1'b1;
    n = 0;
    while (!in_ready_v[i] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", W'(in_ready_v[i]), W'(1));
    @(posedge clk); #1;
    in_valid_v[i] = 1'b0;
    in_data = ~d; in_key = ~k; in_mode = ~mode;
  endtask

  task automatic wait_done(input int unsigned i, output logic [W-1:0] res);
    int unsigned n;
    n = 0;
    while (!out_valid_v[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("done_timeout", W'(out_valid_v[i]), W'(1));
    res = out_data_v[i];
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input int unsigned i, input logic mode, input logic [W-1:0] d,
                     input logic [W-1:0] k, input logic [63:0] m, output logic [W-1:0] res);
    start(i, mode, d, k, m);
    wait_done(i, res);
    aux_mask = '0;
  endtask

  initial begin
    logic [W-1:0] r, c, p, k, held;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", W'(in_ready_v[0]), W'(1));
    chk("reset_out_valid", W'(out_valid_v[0]), W'(0));
    chk("reset_out_data", out_data_v[0], '0);
    rst = 1'b1;

    chk("model_enc_p1", model(1'b0, 128'h1, '0, '0, 8, 1), 128'h100);
    chk("model_dec_c100", model(1'b1, 128'h100, '0, '0, 8, 1), 128'h1);
    chk("model_mask_ff", model(1'b0, '0, '0, 64'hFF, 8, 1), 128'hFF);
    chk("model_r3_a7", model(1'b0, '0, 128'h1, '0, 3, 7), 128'h8208);

    run(0, 1'b0, 128'h1, '0, '0, r);
    chk("t1_enc", r, 128'h100);
    run(0, 1'b1, 128'h100, '0, '0, r);
    chk("t2_dec", r, 128'h1);
    run(0, 1'b0, '0, '0, 64'hFF, r);
    chk("t4_mask", r, 128'hFF);
    run(1, 1'b0, '0, 128'h1, '0, r);
    chk("r1_enc_lit", r, 128'h2);
    run(2, 1'b0, '0, 128'h1, '0, r);
    chk("r3_enc_lit", r, 128'h8208);

    for (int unsigned i = 0; i < NI; i++) begin
      for (int t = 0; t < 3; t++) begin
        p = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        run(i, 1'b0, p, k, '0, c);
        run(i, 1'b1, c, k, '0, r);
        chk($sformatf("roundtrip[%0d]", i), r, p);
      end
    end

    out_ready = 1'b0;
    p = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    k = 128'h0F0F_0000_1111_2222_3333_4444_5555_6666;
    start(0, 1'b0, p, k, '0);
    wait_done(0, held);
    for (int n = 0; n < 5; n++) begin
      if (n == 1) begin
        @(posedge clk); #1;
        in_data = '1; in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
      end
      @(negedge clk);
      chk("bp_out_valid", W'(out_valid_v[0]), W'(1));
      chk("bp_in_ready", W'(in_ready_v[0]), W'(0));
      chk("bp_out_data", out_data_v[0], held);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    repeat (12) @(negedge clk);
    chk("bp_after_idle", W'(in_ready_v[0]), W'(1));
    run(0, 1'b1, held, k, '0, r);
    chk("bp_roundtrip", r, p);

    start(0, 1'b0, 128'h1, '0, '0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_in_ready", W'(in_ready_v[0]), W'(1));
    chk("rst_out_valid", W'(out_valid_v[0]), W'(0));
    chk("rst_out_data", out_data_v[0], '0);
    chk("rst_busy", W'(busy_v[0]), W'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run(0, 1'b0, 128'h1, '0, '0, r);
    chk("t6_after_reset", r, 128'h100);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
